// File: rtl/flat_array_unpacker.sv
// Accepts one flat ROWS*COLS*WIDTH frame and streams it out one element per
// handshake in row-major order, tagged with row/column indices and eol/eof flags.
module flat_array_unpacker #(
    parameter int ROWS  = 16,
    parameter int COLS  = 9,
    parameter int WIDTH = 32,
    parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic                        i_frame_valid,
    output logic                        o_frame_ready,
    input  logic [ROWS*COLS*WIDTH-1:0]  i_frame_data,
    output logic                        o_elem_valid,
    input  logic                        i_elem_ready,
    output logic [WIDTH-1:0]            o_elem_data,
    output logic [RW-1:0]               o_elem_row,
    output logic [CW-1:0]               o_elem_col,
    output logic                        o_elem_eol,
    output logic                        o_elem_eof,
    output logic                        o_busy,
    output logic [15:0]                 o_frame_cnt
);

    localparam int NELEM = ROWS * COLS;
    localparam int FW    = NELEM * WIDTH;
    localparam int IW    = RW + CW;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state, state_next;
    logic [RW-1:0]   row, row_next;
    logic [CW-1:0]   col, col_next;
    logic [15:0]     frame_cnt, frame_cnt_next;
    logic [FW-1:0]   frame_buf;
    logic [IW-1:0]   elem_idx;
    logic [WIDTH-1:0] elem_data;
    logic            elem_valid;
    logic            eol;
    logic            eof;
    logic            beat;
    logic            frame_ready;
    logic            accept;

    assign elem_valid = (state == STREAM);
    assign eol        = elem_valid && (col == COL_LAST);
    assign eof        = eol && (row == ROW_LAST);
    assign beat       = elem_valid && i_elem_ready;

    // A new frame may land in the same cycle the previous eof beat leaves, giving zero-bubble streaming.
    assign frame_ready = i_rst_n && !i_flush && ((state == IDLE) || (beat && eof));
    assign accept      = i_frame_valid && frame_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            row       <= row_next;
            col       <= col_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    // Buffer contents are meaningless outside STREAM, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            frame_buf <= i_frame_data;
        end
    end

    always_comb begin
        state_next     = state;
        row_next       = row;
        col_next       = col;
        frame_cnt_next = frame_cnt;
        if (beat && eof && !i_flush) begin
            frame_cnt_next = frame_cnt + 16'd1;
        end
        if (i_flush) begin
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
        end else if (accept) begin
            state_next = STREAM;
            row_next   = '0;
            col_next   = '0;
        end else if (beat) begin
            if (eof) begin
                state_next = IDLE;
                row_next   = '0;
                col_next   = '0;
            end else if (eol) begin
                row_next = row + RW'(1);
                col_next = '0;
            end else begin
                col_next = col + CW'(1);
            end
        end
    end

    assign elem_idx = IW'(row) * IW'(COLS) + IW'(col);

    always_comb begin
        elem_data = '0;
        for (int e = 0; e < NELEM; e++) begin
            if (elem_idx == IW'(e)) begin
                elem_data = frame_buf[e*WIDTH +: WIDTH];
            end
        end
    end

    assign o_frame_ready = frame_ready;
    assign o_elem_valid  = elem_valid;
    assign o_elem_data   = elem_valid ? elem_data : '0;
    assign o_elem_row    = row;
    assign o_elem_col    = col;
    assign o_elem_eol    = eol;
    assign o_elem_eof    = eof;
    assign o_busy        = elem_valid;
    assign o_frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_flat_array_unpacker.sv
// Randomised bench for flat_array_unpacker: a queue-based model expands each
// accepted frame into its row-major beat list and observed beats are compared to it.
module tb_flat_array_unpacker;

    localparam int ROWS  = 16;
    localparam int COLS  = 9;
    localparam int WIDTH = 32;
    localparam int NB    = ROWS * COLS;
    localparam int FW    = NB * WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            flush;
    logic            frame_valid;
    logic            frame_ready;
    logic [FW-1:0]   frame_data;
    logic            elem_valid;
    logic            elem_ready;
    logic [31:0]     elem_data;
    logic [3:0]      elem_row;
    logic [3:0]      elem_col;
    logic            eol;
    logic            eof;
    logic            busy;
    logic [15:0]     frame_cnt;

    logic            a_frame_valid, a_frame_ready, a_elem_valid, a_elem_ready;
    logic [7:0]      a_frame_data, a_elem_data;
    logic [0:0]      a_row, a_col;
    logic            a_eol, a_eof, a_busy;
    logic [15:0]     a_frame_cnt;

    logic            b_frame_valid, b_frame_ready, b_elem_valid, b_elem_ready;
    logic [47:0]     b_frame_data;
    logic [15:0]     b_elem_data;
    logic [1:0]      b_row;
    logic [0:0]      b_col;
    logic            b_eol, b_eof, b_busy;
    logic [15:0]     b_frame_cnt;

    flat_array_unpacker #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_frame_valid(frame_valid), .o_frame_ready(frame_ready), .i_frame_data(frame_data),
        .o_elem_valid(elem_valid), .i_elem_ready(elem_ready), .o_elem_data(elem_data),
        .o_elem_row(elem_row), .o_elem_col(elem_col), .o_elem_eol(eol), .o_elem_eof(eof),
        .o_busy(busy), .o_frame_cnt(frame_cnt)
    );

    flat_array_unpacker #(.ROWS(1), .COLS(1), .WIDTH(8)) u_dut_1x1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0),
        .i_frame_valid(a_frame_valid), .o_frame_ready(a_frame_ready), .i_frame_data(a_frame_data),
        .o_elem_valid(a_elem_valid), .i_elem_ready(a_elem_ready), .o_elem_data(a_elem_data),
        .o_elem_row(a_row), .o_elem_col(a_col), .o_elem_eol(a_eol), .o_elem_eof(a_eof),
        .o_busy(a_busy), .o_frame_cnt(a_frame_cnt)
    );

    flat_array_unpacker #(.ROWS(3), .COLS(1), .WIDTH(16)) u_dut_3x1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0),
        .i_frame_valid(b_frame_valid), .o_frame_ready(b_frame_ready), .i_frame_data(b_frame_data),
        .o_elem_valid(b_elem_valid), .i_elem_ready(b_elem_ready), .o_elem_data(b_elem_data),
        .o_elem_row(b_row), .o_elem_col(b_col), .o_elem_eol(b_eol), .o_elem_eof(b_eof),
        .o_busy(b_busy), .o_frame_cnt(b_frame_cnt)
    );

    typedef struct {
        int          row;
        int          col;
        logic [31:0] data;
        logic        eol;
        logic        eof;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    exp_cnt = 0;
    int    last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_push(input logic [FW-1:0] f);
        beat_t b;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                b.row  = r;
                b.col  = c;
                b.data = f[(r*COLS + c)*WIDTH +: WIDTH];
                b.eol  = (c == COLS - 1);
                b.eof  = (c == COLS - 1) && (r == ROWS - 1);
                b.cyc  = 0;
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < NB; i++) f[i*WIDTH +: WIDTH] = $urandom;
        return f;
    endfunction

    // One clock of traffic: called at posedge+1, records handshakes, returns at next posedge+1.
    task automatic tick(input logic rdy, output logic acc);
        beat_t b;
        elem_ready = rdy;
        #1;
        acc = frame_valid && frame_ready;
        if (elem_valid && rdy) begin
            b.row = int'(elem_row); b.col = int'(elem_col); b.data = elem_data;
            b.eol = eol; b.eof = eof; b.cyc = cyc;
            obs_q.push_back(b);
            if (obs_q.size() <= exp_q.size() && exp_q[obs_q.size()-1].eof && !flush) exp_cnt++;
        end
        if (acc) begin
            model_push(frame_data);
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; frame_valid = 1'b0; elem_ready = 1'b0; frame_data = '0;
        a_frame_valid = 1'b0; a_elem_ready = 1'b0; a_frame_data = '0;
        b_frame_valid = 1'b0; b_elem_ready = 1'b0; b_frame_data = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({frame_ready, elem_valid, busy, frame_cnt, elem_row, elem_col, eol, eof, elem_data} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got rdy%b v%b busy%b cnt%0d r%0d c%0d eol%b eof%b d%h, want all 0",
                     frame_ready, elem_valid, busy, frame_cnt, elem_row, elem_col, eol, eof, elem_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (frame_ready !== 1'b1 || elem_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: got rdy%b v%b busy%b cnt%0d, want rdy1 v0 busy0 cnt0",
                     frame_ready, elem_valid, busy, frame_cnt);
        end
    endtask

    task automatic test_single_frame();
        logic acc;
        int   guard, acc_c;
        exp_q.delete(); obs_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame_data[(r*COLS + c)*WIDTH +: WIDTH] = {8'(r), 8'(c), 16'hA5A5};
        frame_valid = 1'b1;
        tick(1'b1, acc);
        frame_valid = 1'b0;
        acc_c = last_acc_cyc;
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", acc); end
        guard = 0;
        while (obs_q.size() < NB && guard < 400) begin tick(1'b1, acc); guard++; end
        checks++;
        if (obs_q.size() != NB) begin errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].row !== exp_q[i].row || obs_q[i].col !== exp_q[i].col || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof || obs_q[i].cyc !== acc_c + 1 + i) begin
                errors++;
                $display("FAIL single_beat %0d: got r%0d c%0d d%h eol%b eof%b cyc%0d, want r%0d c%0d d%h eol%b eof%b cyc%0d",
                         i, obs_q[i].row, obs_q[i].col, obs_q[i].data, obs_q[i].eol, obs_q[i].eof, obs_q[i].cyc,
                         exp_q[i].row, exp_q[i].col, exp_q[i].data, exp_q[i].eol, exp_q[i].eof, acc_c + 1 + i);
            end
        end
        if (obs_q.size() == NB) begin
            checks++;
            if (obs_q[8].eol !== 1'b1 || obs_q[8].row !== 0 || obs_q[8].col !== 8) begin
                errors++;
                $display("FAIL single_beat8: got eol%b r%0d c%0d, want eol1 r0 c8", obs_q[8].eol, obs_q[8].row, obs_q[8].col);
            end
            checks++;
            if (obs_q[143].eof !== 1'b1 || obs_q[143].data !== 32'h0F08A5A5) begin
                errors++;
                $display("FAIL single_beat143: got eof%b d%h, want eof1 d0f08a5a5", obs_q[143].eof, obs_q[143].data);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_cnt) || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got cnt%0d busy%b, want cnt%0d busy0", frame_cnt, busy, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic        acc, rdy, stalled;
        logic [42:0] snap, cur;
        int          guard;
        exp_q.delete(); obs_q.delete();
        frame_data = rand_frame();
        frame_valid = 1'b1;
        tick(1'b1, acc);
        frame_valid = 1'b0;
        stalled = 1'b0;
        snap = '0;
        guard = 0;
        while (obs_q.size() < NB && guard < 2000) begin
            rdy = 1'($urandom_range(0, 1));
            cur = {elem_valid, elem_data, elem_row, elem_col, eol, eof};
            if (stalled) begin
                checks++;
                if (cur !== snap) begin
                    errors++;
                    $display("FAIL bp_hold: got %h want %h", cur, snap);
                end
            end
            snap = cur;
            stalled = elem_valid && !rdy;
            tick(rdy, acc);
            guard++;
        end
        checks++;
        if (obs_q.size() != NB) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].row !== exp_q[i].row || obs_q[i].col !== exp_q[i].col || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                errors++;
                $display("FAIL bp_beat %0d: got r%0d c%0d d%h, want r%0d c%0d d%h", i, obs_q[i].row, obs_q[i].col,
                         obs_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic          acc;
        logic [FW-1:0] f2;
        int            guard, n_acc, acc2_cyc;
        exp_q.delete(); obs_q.delete();
        frame_data = rand_frame();
        f2 = rand_frame();
        frame_valid = 1'b1;
        tick(1'b1, acc);
        n_acc = acc ? 1 : 0;
        frame_data = f2;
        acc2_cyc = -1;
        guard = 0;
        while (obs_q.size() < 2*NB && guard < 800) begin
            tick(1'b1, acc);
            if (acc) begin n_acc++; acc2_cyc = last_acc_cyc; frame_valid = 1'b0; end
            guard++;
        end
        frame_valid = 1'b0;
        checks++;
        if (n_acc != 2 || obs_q.size() != 2*NB) begin
            errors++;
            $display("FAIL b2b_count: got accepts %0d beats %0d, want 2 and %0d", n_acc, obs_q.size(), 2*NB);
        end
        if (obs_q.size() == 2*NB) begin
            checks++;
            if (acc2_cyc !== obs_q[NB-1].cyc) begin
                errors++;
                $display("FAIL b2b_accept_cycle: got %0d want %0d", acc2_cyc, obs_q[NB-1].cyc);
            end
            checks++;
            if (obs_q[NB].cyc !== obs_q[NB-1].cyc + 1 || obs_q[NB].row !== 0 || obs_q[NB].col !== 0) begin
                errors++;
                $display("FAIL b2b_gap: got cyc%0d r%0d c%0d, want cyc%0d r0 c0", obs_q[NB].cyc, obs_q[NB].row,
                         obs_q[NB].col, obs_q[NB-1].cyc + 1);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].row !== exp_q[i].row || obs_q[i].col !== exp_q[i].col || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].eol !== exp_q[i].eol || obs_q[i].eof !== exp_q[i].eof) begin
                errors++;
                $display("FAIL b2b_beat %0d: got r%0d c%0d d%h, want r%0d c%0d d%h", i, obs_q[i].row, obs_q[i].col,
                         obs_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_flush();
        logic acc;
        int   guard;
        exp_q.delete(); obs_q.delete();
        frame_data = rand_frame();
        frame_valid = 1'b1;
        tick(1'b1, acc);
        frame_valid = 1'b0;
        guard = 0;
        while (obs_q.size() < 51 && guard < 200) begin tick(1'b1, acc); guard++; end
        flush = 1'b1;
        frame_valid = 1'b1;
        frame_data = rand_frame();
        elem_ready = 1'b1;
        #1;
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", frame_ready); end
        tick(1'b1, acc);
        checks++;
        if (acc !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b want 0", acc); end
        flush = 1'b0;
        frame_valid = 1'b0;
        checks++;
        if (elem_valid !== 1'b0 || busy !== 1'b0 || elem_row !== 4'd0 || elem_col !== 4'd0 || frame_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_state: got v%b busy%b r%0d c%0d cnt%0d, want v0 busy0 r0 c0 cnt%0d",
                     elem_valid, busy, elem_row, elem_col, frame_cnt, exp_cnt);
        end
        checks++;
        if (obs_q.size() != 52) begin errors++; $display("FAIL flush_delivered: got %0d want 52", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].row !== exp_q[i].row || obs_q[i].col !== exp_q[i].col || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL flush_beat %0d: got r%0d c%0d d%h, want r%0d c%0d d%h", i, obs_q[i].row, obs_q[i].col,
                         obs_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
            end
        end
        exp_q.delete(); obs_q.delete();
        frame_data = rand_frame();
        frame_valid = 1'b1;
        tick(1'b1, acc);
        frame_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL flush_reaccept: got %b want 1", acc); end
        guard = 0;
        while (obs_q.size() < NB && guard < 400) begin tick(1'b1, acc); guard++; end
        checks++;
        if (obs_q.size() != NB) begin errors++; $display("FAIL flush_refill_count: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].row !== exp_q[i].row || obs_q[i].col !== exp_q[i].col || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].cyc !== last_acc_cyc + 1 + i) begin
                errors++;
                $display("FAIL flush_refill_beat %0d: got r%0d c%0d d%h cyc%0d, want r%0d c%0d d%h cyc%0d", i,
                         obs_q[i].row, obs_q[i].col, obs_q[i].data, obs_q[i].cyc, exp_q[i].row, exp_q[i].col,
                         exp_q[i].data, last_acc_cyc + 1 + i);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_async_reset();
        logic acc;
        int   guard;
        exp_q.delete(); obs_q.delete();
        frame_data = rand_frame();
        frame_valid = 1'b1;
        tick(1'b1, acc);
        frame_valid = 1'b0;
        guard = 0;
        while (obs_q.size() < 70 && guard < 200) begin tick(1'b1, acc); guard++; end
        checks++;
        if (elem_valid !== 1'b1 || elem_row !== 4'd7 || elem_col !== 4'd7) begin
            errors++;
            $display("FAIL arst_pre: got v%b r%0d c%0d, want v1 r7 c7", elem_valid, elem_row, elem_col);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_ready, elem_valid, busy, frame_cnt, elem_row, elem_col, eol, eof, elem_data} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: got rdy%b v%b busy%b cnt%0d r%0d c%0d d%h, want all 0",
                     frame_ready, elem_valid, busy, frame_cnt, elem_row, elem_col, elem_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_q.delete(); obs_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b0 || elem_valid !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL arst_release: got rdy%b busy%b v%b cnt%0d, want rdy1 busy0 v0 cnt0",
                     frame_ready, busy, elem_valid, frame_cnt);
        end
    endtask

    task automatic test_small_params();
        logic [7:0]  prev;
        logic [47:0] bf;
        int          a_exp_cnt;
        a_exp_cnt = 0;
        prev = '0;
        a_frame_valid = 1'b1;
        a_elem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (a_frame_ready !== 1'b1) begin errors++; $display("FAIL 1x1_ready %0d: got %b want 1", k, a_frame_ready); end
            if (k > 0) begin
                checks++;
                if (a_elem_valid !== 1'b1 || a_eol !== 1'b1 || a_eof !== 1'b1 || a_elem_data !== prev ||
                    a_row !== 1'b0 || a_col !== 1'b0) begin
                    errors++;
                    $display("FAIL 1x1_beat %0d: got v%b eol%b eof%b d%h, want v1 eol1 eof1 d%h",
                             k, a_elem_valid, a_eol, a_eof, a_elem_data, prev);
                end
                a_exp_cnt++;
            end
            a_frame_data = 8'($urandom);
            prev = a_frame_data;
            @(posedge clk);
            #1;
        end
        a_frame_valid = 1'b0;
        checks++;
        if (a_elem_valid !== 1'b1 || a_elem_data !== prev) begin
            errors++;
            $display("FAIL 1x1_last: got v%b d%h, want v1 d%h", a_elem_valid, a_elem_data, prev);
        end
        a_exp_cnt++;
        @(posedge clk);
        #1;
        checks++;
        if (a_elem_valid !== 1'b0 || a_frame_cnt !== 16'(a_exp_cnt)) begin
            errors++;
            $display("FAIL 1x1_done: got v%b cnt%0d, want v0 cnt%0d", a_elem_valid, a_frame_cnt, a_exp_cnt);
        end

        bf = {16'($urandom), 16'($urandom), 16'($urandom)};
        b_frame_data = bf;
        b_frame_valid = 1'b1;
        b_elem_ready = 1'b1;
        @(posedge clk);
        #1;
        b_frame_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (b_elem_valid !== 1'b1 || b_row !== 2'(r) || b_col !== 1'b0 || b_eol !== 1'b1 ||
                b_eof !== (r == 2) || b_elem_data !== bf[r*16 +: 16]) begin
                errors++;
                $display("FAIL 3x1_beat %0d: got v%b r%0d c%0d eol%b eof%b d%h, want v1 r%0d c0 eol1 eof%b d%h",
                         r, b_elem_valid, b_row, b_col, b_eol, b_eof, b_elem_data, r, (r == 2), bf[r*16 +: 16]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (b_elem_valid !== 1'b0 || b_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL 3x1_done: got v%b cnt%0d, want v0 cnt1", b_elem_valid, b_frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_small_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
